bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//  Parallel-to-serial front end for the serial pattern-detector chain. Accepts WIDTH-bit
//  words over a valid/ready handshake and presents them one bit per enabled cycle on
//  ser_out, which drives the detector's serial input i directly. Back-to-back words
//  stream with no idle bit between them, so a pattern that spans a word boundary is
//  still detected. Between words, ser_out holds IDLE_BIT.
// PARAMETERS
//  WIDTH      8  word length in bits (>=2)
//  MSB_FIRST  1  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//  IDLE_BIT   0  ser_out value in IDLE and during reset
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous reset, active-low
//  load_data   in   WIDTH  word to serialize
//  load_valid  in   1      load_data valid
//  load_ready  out  1      word accepted at the edge where load_valid && load_ready
//  shift_en    in   1      bit-rate enable; the bit advances only at edges where it is 1
//  ser_out     out  1      serial bit, registered; feeds the detector input i
//  ser_valid   out  1      ser_out carries a data bit (not idle fill)
//  busy        out  1      word in flight (state SHIFT)
//  frame_done  out  1      1-cycle pulse after the last bit of a word has been consumed
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE, cnt=0, shreg=0, ser_out=IDLE_BIT, ser_valid=0,
//   busy=0, frame_done=0. Reset wins over all other inputs, including mid-word; the
//   partial word is discarded.
//  States:
//   IDLE: load_ready=1; ser_valid=0.
//   SHIFT: ser_valid=1; cnt = index of the bit currently displayed (0..WIDTH-1).
//  IDLE->SHIFT on accept. In the next cycle, ser_out = the first bit and cnt=0.
//   Latency from accept edge to first bit = 1 cycle. shift_en is not required for the load.
//  SHIFT, shift_en=0: all state holds; ser_out and cnt are stable (stall).
//  SHIFT, shift_en=1, cnt<WIDTH-1: next bit is shown and cnt increments.
//  SHIFT, shift_en=1, cnt==WIDTH-1 (last bit consumed):
//   - load_ready=1 this cycle (combinational from state, cnt and shift_en).
//   - If load_valid: the new word loads and its first bit shows next cycle. State stays
//     SHIFT, there is no gap, and ser_valid stays 1.
//   - Otherwise: next state is IDLE; ser_out=IDLE_BIT and ser_valid=0.
//   - In both cases frame_done=1 for exactly the next cycle.
//  load_ready is 0 in SHIFT except in the last-bit/shift_en cycle. load_data is sampled
//   only at accept edges; load_valid without ready has no effect.
//  Bit order: MSB_FIRST=1 shifts left and outputs shreg[WIDTH-1]; MSB_FIRST=0 shifts
//   right and outputs shreg[0]. Vacated bits fill with 0.
//  cnt width is $clog2(WIDTH); the counter never wraps past WIDTH-1.
//  All outputs except load_ready are registered.
// STRUCTURE
//  Package serdes_pkg holds:
//   - state enum ser_state_t {S_IDLE, S_SHIFT}
//   - function cnt_w(WIDTH) returning $clog2(WIDTH)
//  Single module, no sub-modules. Three processes: state/counter register,
//  next-state logic, shift register with output register.
// TESTING
//  1 WIDTH=8, MSB_FIRST=1, shift_en=1, load 8'b1011_0000: ser_out=1,0,1,1,0,0,0,0
//    on cycles +1..+8. frame_done=1 on cycle +9, where ser_valid=0 and ser_out=0.
//  2 Back-to-back: load 8'hB0 then 8'h5A with load_valid held high. 16 contiguous
//    ser_valid=1 cycles; the second accept occurs exactly in the last-bit cycle;
//    two frame_done pulses.
//  3 Stall: drop shift_en for 3 cycles at cnt=3. ser_out and cnt hold for 3 cycles,
//    load_ready=0 throughout, and the remaining bits resume in order.
//  4 Reset mid-word: rst=0 at cnt=4. On the next cycle ser_out=IDLE_BIT,
//    ser_valid=busy=0 and load_ready=1. The next word restarts cleanly at bit 0.
//  5 MSB_FIRST=0, load 8'b0000_1101: ser_out=1,0,1,1,0,0,0,0.
//    IDLE_BIT=1: ser_out=1 while idle.
//  6 Chain with the detector (serial sequence 1,0,1,1,0): stream 8'b1011_0101 then
//    8'b1000_0000. A match spans the word boundary, and y pulses when the boundary 0
//    bit is present.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial front end.
// Combinational only (types, constant function); no latency.
// No backpressure: declarations only.
package serdes_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Bit-index counter width for a word of the given length.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word load handshake between a word producer and the serializer.
// No storage; signals pass straight through.
// Producer holds load_data/load_valid until load_ready is seen at an edge.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial: WIDTH-bit words out one bit per shift_en cycle, no gap between words.
// First bit appears 1 cycle after the accept edge; all outputs registered except load_ready.
// load_ready only in IDLE or in the last-bit cycle with shift_en; shift_en=0 stalls everything.
module bit_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  bit_serializer_if.slave ld,
  input  logic            shift_en,
  output logic            ser_out,
  output logic            ser_valid,
  output logic            busy,
  output logic            frame_done
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  ser_state_t       state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shf;
  logic             last;
  logic             accept;

  // Bit that is on the wire for a given register image.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // The displayed bit is being consumed and it is the final one of the word.
  assign last          = (state == S_SHIFT) && shift_en && (cnt == CNT_LAST);
  assign ld.load_ready = (state == S_IDLE) || last;
  assign accept        = ld.load_valid && ld.load_ready;
  assign shreg_shf     = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // Next state and bit index; a word accepted in the last-bit cycle chains without a gap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_SHIFT;
          cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (shift_en) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = ld.load_valid ? S_SHIFT : S_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State/counter register plus the registered status outputs derived from it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      busy       <= (state_nxt == S_SHIFT);
      ser_valid  <= (state_nxt == S_SHIFT);
      frame_done <= last;
    end
  end

  // Shift register and serial output register; a new word takes priority over shifting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg   <= '0;
      ser_out <= IDLE_BIT;
    end else if (accept) begin
      shreg   <= ld.load_data;
      ser_out <= head(ld.load_data);
    end else if ((state == S_SHIFT) && shift_en) begin
      shreg   <= shreg_shf;
      ser_out <= last ? IDLE_BIT : head(shreg_shf);
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: two instances (MSB-first/idle 0 and LSB-first/idle 1).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected bit streams are hand-computed constants.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst;
  logic shift_en_a, ser_out_a, ser_valid_a, busy_a, frame_done_a;
  logic shift_en_b, ser_out_b, ser_valid_b, busy_b, frame_done_b;
  int   checks = 0;
  int   errors = 0;

  bit_serializer_if #(.WIDTH(8)) bus_a ();
  bit_serializer_if #(.WIDTH(8)) bus_b ();

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .ld         (bus_a),
    .shift_en   (shift_en_a),
    .ser_out    (ser_out_a),
    .ser_valid  (ser_valid_a),
    .busy       (busy_a),
    .frame_done (frame_done_a)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .ld         (bus_b),
    .shift_en   (shift_en_b),
    .ser_out    (ser_out_b),
    .ser_valid  (ser_valid_b),
    .busy       (busy_b),
    .frame_done (frame_done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] stream;
    logic [15:0] mask;
    logic [4:0]  win;
    int          vcnt;
    int          fcnt;

    rst              = 1'b0;
    shift_en_a       = 1'b0;
    shift_en_b       = 1'b0;
    bus_a.load_valid = 1'b0;
    bus_a.load_data  = '0;
    bus_b.load_valid = 1'b0;
    bus_b.load_data  = '0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_ser_out_a",    32'(ser_out_a), 0);
    chk("rst_ser_valid_a",  32'(ser_valid_a), 0);
    chk("rst_busy_a",       32'(busy_a), 0);
    chk("rst_frame_done_a", 32'(frame_done_a), 0);
    chk("rst_ready_a",      32'(bus_a.load_ready), 1);
    chk("rst_ser_out_b",    32'(ser_out_b), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ser_out_b", 32'(ser_out_b), 1);

    // T1: single word 1011_0000, MSB first
    w                = 8'hB0;
    shift_en_a       = 1'b1;
    bus_a.load_data  = w;
    bus_a.load_valid = 1'b1;
    #1;
    chk("t1_ready_idle", 32'(bus_a.load_ready), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_a.load_valid = 1'b0;
      chk($sformatf("t1_bit%0d", i), 32'(ser_out_a), 32'(w[7-i]));
      chk($sformatf("t1_valid%0d", i), 32'(ser_valid_a), 1);
      if (i == 0) chk("t1_busy", 32'(busy_a), 1);
      if (i == 0) chk("t1_cnt0", 32'(u_dut_a.cnt), 0);
      if (i == 3) chk("t1_ready_mid", 32'(bus_a.load_ready), 0);
      if (i == 7) chk("t1_ready_last", 32'(bus_a.load_ready), 1);
    end
    @(negedge clk);
    chk("t1_frame_done", 32'(frame_done_a), 1);
    chk("t1_end_valid",  32'(ser_valid_a), 0);
    chk("t1_end_out",    32'(ser_out_a), 0);
    chk("t1_end_busy",   32'(busy_a), 0);
    @(negedge clk);
    chk("t1_fd_pulse", 32'(frame_done_a), 0);

    // T2: back-to-back B0 then 5A with valid held
    stream           = 16'hB05A;
    bus_a.load_data  = 8'hB0;
    bus_a.load_valid = 1'b1;
    vcnt             = 0;
    fcnt             = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) bus_a.load_data = 8'h5A;
      if (i == 8) bus_a.load_valid = 1'b0;
      chk($sformatf("t2_bit%0d", i), 32'(ser_out_a), 32'(stream[15-i]));
      vcnt = vcnt + int'(ser_valid_a);
      fcnt = fcnt + int'(frame_done_a);
      if (i == 6) chk("t2_ready_early", 32'(bus_a.load_ready), 0);
      if (i == 7) chk("t2_ready_last",  32'(bus_a.load_ready), 1);
      if (i == 8) chk("t2_fd_boundary", 32'(frame_done_a), 1);
    end
    @(negedge clk);
    fcnt = fcnt + int'(frame_done_a);
    chk("t2_end_valid", 32'(ser_valid_a), 0);
    chk("t2_valid_run", 32'(vcnt), 16);
    chk("t2_fd_count",  32'(fcnt), 2);
    @(negedge clk);

    // T3: stall at cnt=3, word 1011_0110
    w                = 8'hB6;
    bus_a.load_data  = w;
    bus_a.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_a.load_valid = 1'b0;
      chk($sformatf("t3_bit%0d", i), 32'(ser_out_a), 32'(w[7-i]));
    end
    chk("t3_cnt_at_stall", 32'(u_dut_a.cnt), 3);
    shift_en_a = 1'b0;
    #1;
    chk("t3_ready_stall0", 32'(bus_a.load_ready), 0);
    for (int s = 1; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("t3_hold_cnt%0d", s), 32'(u_dut_a.cnt), 3);
      chk($sformatf("t3_hold_out%0d", s), 32'(ser_out_a), 32'(w[4]));
      chk($sformatf("t3_hold_rdy%0d", s), 32'(bus_a.load_ready), 0);
    end
    shift_en_a = 1'b1;
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t3_bit%0d", i), 32'(ser_out_a), 32'(w[7-i]));
      chk($sformatf("t3_cnt%0d", i), 32'(u_dut_a.cnt), 32'(i));
    end
    @(negedge clk);
    chk("t3_frame_done", 32'(frame_done_a), 1);
    @(negedge clk);

    // T4: reset mid-word at cnt=4, then restart with 1100_0011
    bus_a.load_data  = 8'hB6;
    bus_a.load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_a.load_valid = 1'b0;
    end
    chk("t4_cnt_before", 32'(u_dut_a.cnt), 4);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_rst_out",   32'(ser_out_a), 0);
    chk("t4_rst_valid", 32'(ser_valid_a), 0);
    chk("t4_rst_busy",  32'(busy_a), 0);
    chk("t4_rst_ready", 32'(bus_a.load_ready), 1);
    chk("t4_rst_fd",    32'(frame_done_a), 0);
    rst              = 1'b1;
    w                = 8'hC3;
    bus_a.load_data  = w;
    bus_a.load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_a.load_valid = 1'b0;
      chk($sformatf("t4_bit%0d", i), 32'(ser_out_a), 32'(w[7-i]));
      if (i == 0) chk("t4_restart_cnt", 32'(u_dut_a.cnt), 0);
    end
    @(negedge clk);
    chk("t4_frame_done", 32'(frame_done_a), 1);

    // T5: LSB first, idle fill 1, word 0000_1101 -> 1,0,1,1,0,0,0,0
    w                = 8'h0D;
    shift_en_b       = 1'b1;
    bus_b.load_data  = w;
    bus_b.load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_b.load_valid = 1'b0;
      chk($sformatf("t5_bit%0d", i), 32'(ser_out_b), 32'(w[i]));
      if (i == 0) chk("t5_busy", 32'(busy_b), 1);
    end
    @(negedge clk);
    chk("t5_frame_done", 32'(frame_done_b), 1);
    chk("t5_idle_out",   32'(ser_out_b), 1);
    chk("t5_idle_valid", 32'(ser_valid_b), 0);

    // T6: 1011_0101 then 1000_0000; pattern 1,0,1,1,0 ends at stream index 4 and 9
    bus_a.load_data  = 8'hB5;
    bus_a.load_valid = 1'b1;
    win              = '0;
    mask             = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) bus_a.load_data = 8'h80;
      if (i == 8) bus_a.load_valid = 1'b0;
      chk($sformatf("t6_valid%0d", i), 32'(ser_valid_a), 1);
      win = {win[3:0], ser_out_a};
      if (i >= 4 && win == 5'b10110) mask[i] = 1'b1;
    end
    chk("t6_match_mask", 32'(mask), 32'h0210);
    @(negedge clk);
    chk("t6_frame_done", 32'(frame_done_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
